// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive FSM, its serial line, the bit-delay
// counter it programs, and the consumer of received words.
interface uart_rx_fsm_if;
    logic        rx;
    logic [16:0] dly_value;
    logic        dly_set;
    logic        dly_done;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    modport master (
        input  rx,
        input  dly_done,
        output dly_value,
        output dly_set,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        output dly_done,
        input  dly_value,
        input  dly_set,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive FSM: finds the start edge, times mid-bit samples through an
// external bit-delay counter, assembles an LSB-first word and flags errors.
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fsm_if.master bus
);
    localparam logic [16:0] HALF_BIT_VAL   = 17'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] FULL_BIT_VAL   = 17'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BIT       = 4'(DATA_BITS - 1);
    localparam int          MSB            = DATA_BITS - 1;
    localparam logic        PARITY_ON      = (PARITY_EN != 0) ? 1'b1 : 1'b0;
    localparam logic        PARITY_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Upper bits of word are always zero, so they do not disturb the XOR.
    function automatic logic parity_mismatch(input logic [7:0] word,
                                             input logic       sample,
                                             input logic       odd);
        return (((^word) ^ sample) != odd) ? 1'b1 : 1'b0;
    endfunction

    state_t      state_r, state_s;
    logic        rx_meta_r, rx_sync_r, rx_dly_r;
    logic        fall_s;
    logic [7:0]  shift_r, shift_s;
    logic [3:0]  bit_cnt_r, bit_cnt_s;
    logic        par_mis_r, par_mis_s;
    logic [16:0] dly_value_r, dly_value_s;
    logic        dly_set_r, dly_set_s;
    logic [7:0]  data_out_r, data_out_s;
    logic        data_valid_r, data_valid_s;
    logic        parity_err_r, parity_err_s;
    logic        frame_err_r, frame_err_s;
    logic        busy_r;

    assign fall_s = ~rx_sync_r & rx_dly_r;

    // Two-flop synchronizer on rx plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_dly_r  <= 1'b1;
        end else begin
            rx_meta_r <= bus.rx;
            rx_sync_r <= rx_meta_r;
            rx_dly_r  <= rx_sync_r;
        end
    end

    // Next-state and next-output decode; every sample point is a dly_done pulse.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        bit_cnt_s    = bit_cnt_r;
        par_mis_s    = par_mis_r;
        dly_value_s  = dly_value_r;
        dly_set_s    = 1'b0;
        data_out_s   = data_out_r;
        data_valid_s = 1'b0;
        parity_err_s = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_s     = ST_START;
                    dly_set_s   = 1'b1;
                    dly_value_s = HALF_BIT_VAL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bus.dly_done && !rx_sync_r) begin
                    bit_cnt_s   = 4'd0;
                    shift_s     = 8'd0;
                    par_mis_s   = 1'b0;
                    dly_set_s   = 1'b1;
                    dly_value_s = FULL_BIT_VAL;
                    state_s     = ST_DATA;
                end else if (bus.dly_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bus.dly_done) begin
                    shift_s      = {1'b0, shift_r[7:1]};
                    shift_s[MSB] = rx_sync_r;
                    bit_cnt_s    = bit_cnt_r + 4'd1;
                    dly_set_s    = 1'b1;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_s = PARITY_ON ? ST_PARITY : ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bus.dly_done) begin
                    par_mis_s = parity_mismatch(shift_r, rx_sync_r, PARITY_ODD_BIT);
                    dly_set_s = 1'b1;
                    state_s   = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bus.dly_done && rx_sync_r) begin
                    data_out_s   = shift_r;
                    data_valid_s = 1'b1;
                    parity_err_s = PARITY_ON & par_mis_r;
                    state_s      = ST_IDLE;
                end else if (bus.dly_done) begin
                    frame_err_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; busy tracks the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            shift_r      <= 8'd0;
            bit_cnt_r    <= 4'd0;
            par_mis_r    <= 1'b0;
            dly_value_r  <= 17'd0;
            dly_set_r    <= 1'b0;
            data_out_r   <= 8'd0;
            data_valid_r <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            par_mis_r    <= par_mis_s;
            dly_value_r  <= dly_value_s;
            dly_set_r    <= dly_set_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            parity_err_r <= parity_err_s;
            frame_err_r  <= frame_err_s;
            busy_r       <= (state_s != ST_IDLE) ? 1'b1 : 1'b0;
        end
    end

    assign bus.dly_value  = dly_value_r;
    assign bus.dly_set    = dly_set_r;
    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.parity_err = parity_err_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: an 8N1 instance and an 8E1 instance, each
// paired with a behavioural bit-delay counter, CLKS_PER_BIT = 16.
module tb_uart_rx_fsm;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uart_rx_fsm_if a_if ();
    uart_rx_fsm_if p_if ();

    uart_rx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0))
        dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
    uart_rx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0))
        dut_p (.clk(clk), .rst(rst), .bus(p_if.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Delay counter: set in cycle 0 gives done in cycle value.
    logic [16:0] a_cnt, p_cnt;
    logic        a_run, p_run;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_run <= 1'b0; a_cnt <= 17'd0; p_run <= 1'b0; p_cnt <= 17'd0;
        end else begin
            if (a_if.dly_set) begin a_run <= 1'b1; a_cnt <= a_if.dly_value - 17'd1; end
            else if (a_run) begin
                if (a_cnt == 17'd0) a_run <= 1'b0; else a_cnt <= a_cnt - 17'd1;
            end
            if (p_if.dly_set) begin p_run <= 1'b1; p_cnt <= p_if.dly_value - 17'd1; end
            else if (p_run) begin
                if (p_cnt == 17'd0) p_run <= 1'b0; else p_cnt <= p_cnt - 17'd1;
            end
        end
    end
    assign a_if.dly_done = a_run && (a_cnt == 17'd0);
    assign p_if.dly_done = p_run && (p_cnt == 17'd0);

    int         a_dv[$], a_fe[$], a_set[$], a_done[$], a_rise[$], a_fall[$];
    logic [7:0] a_dat[$], p_dat[$];
    logic       a_pe[$], p_pe[$];
    int         p_dv[$], p_fe[$];
    logic       a_busy_q = 1'b0;

    // Event logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_if.data_valid) begin
            a_dv.push_back(cyc); a_dat.push_back(a_if.data_out); a_pe.push_back(a_if.parity_err);
        end
        if (a_if.frame_err) a_fe.push_back(cyc);
        if (a_if.dly_set)   a_set.push_back(cyc);
        if (a_if.dly_done)  a_done.push_back(cyc);
        if (a_if.busy && !a_busy_q) a_rise.push_back(cyc);
        if (!a_if.busy && a_busy_q) a_fall.push_back(cyc);
        a_busy_q <= a_if.busy;
        if (p_if.data_valid) begin
            p_dv.push_back(cyc); p_dat.push_back(p_if.data_out); p_pe.push_back(p_if.parity_err);
        end
        if (p_if.frame_err) p_fe.push_back(cyc);
    end

    task automatic clear_logs();
        a_dv.delete(); a_fe.delete(); a_set.delete(); a_done.delete();
        a_rise.delete(); a_fall.delete(); a_dat.delete(); a_pe.delete();
        p_dv.delete(); p_fe.delete(); p_dat.delete(); p_pe.delete();
    endtask

    task automatic drive_bit(input int which, input logic v, input int n);
        if (which == 0) a_if.rx = v; else p_if.rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        drive_bit(which, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], CPB);
        if (has_par) drive_bit(which, par, CPB);
        drive_bit(which, stop, CPB);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks += 8;
        if (a_if.dly_set !== 1'b0) begin errors++; $display("FAIL %s dly_set got %b want 0", tag, a_if.dly_set); end
        if (a_if.dly_value !== 17'd0) begin errors++; $display("FAIL %s dly_value got %0d want 0", tag, a_if.dly_value); end
        if (a_if.data_out !== 8'h00) begin errors++; $display("FAIL %s data_out got %h want 00", tag, a_if.data_out); end
        if (a_if.data_valid !== 1'b0) begin errors++; $display("FAIL %s data_valid got %b want 0", tag, a_if.data_valid); end
        if (a_if.parity_err !== 1'b0) begin errors++; $display("FAIL %s parity_err got %b want 0", tag, a_if.parity_err); end
        if (a_if.frame_err !== 1'b0) begin errors++; $display("FAIL %s frame_err got %b want 0", tag, a_if.frame_err); end
        if (a_if.busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", tag, a_if.busy); end
        if (p_if.busy !== 1'b0) begin errors++; $display("FAIL %s p_busy got %b want 0", tag, p_if.busy); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good_frame();
        clear_logs();
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1, 2 * CPB);
        checks += 3;
        if (a_dv.size() !== 1) begin errors++; $display("FAIL good_dv_count got %0d want 1", a_dv.size()); end
        if (a_fe.size() !== 0) begin errors++; $display("FAIL good_fe_count got %0d want 0", a_fe.size()); end
        if (a_done.size() !== 10 || a_set.size() !== 10) begin
            errors++; $display("FAIL good_sample_count got done=%0d set=%0d want 10/10", a_done.size(), a_set.size());
        end
        if (a_dv.size() == 1) begin
            checks += 2;
            if (a_dat[0] !== 8'hA5) begin errors++; $display("FAIL good_data got %h want a5", a_dat[0]); end
            if (a_pe[0] !== 1'b0) begin errors++; $display("FAIL good_parity_err got %b want 0", a_pe[0]); end
        end
        if (a_done.size() == 10 && a_set.size() == 10 && a_dv.size() == 1) begin
            for (int i = 1; i < 10; i++) begin
                checks++;
                if (a_done[i] - a_done[i-1] !== CPB) begin
                    errors++; $display("FAIL good_spacing[%0d] got %0d want %0d", i, a_done[i] - a_done[i-1], CPB);
                end
            end
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (a_set[i+1] !== a_done[i] + 1) begin
                    errors++; $display("FAIL good_set_after_done[%0d] got %0d want %0d", i, a_set[i+1], a_done[i] + 1);
                end
            end
            checks += 2;
            if (a_done[0] - a_set[0] !== CPB / 2 - 1) begin
                errors++; $display("FAIL good_half_bit got %0d want %0d", a_done[0] - a_set[0], CPB / 2 - 1);
            end
            if (a_dv[0] !== a_done[9] + 1) begin
                errors++; $display("FAIL good_valid_cycle got %0d want %0d", a_dv[0], a_done[9] + 1);
            end
            if (a_rise.size() == 1 && a_fall.size() == 1) begin
                checks += 2;
                if (a_rise[0] !== a_set[0]) begin errors++; $display("FAIL good_busy_rise got %0d want %0d", a_rise[0], a_set[0]); end
                if (a_fall[0] !== a_dv[0]) begin errors++; $display("FAIL good_busy_fall got %0d want %0d", a_fall[0], a_dv[0]); end
            end else begin
                checks++; errors++;
                $display("FAIL good_busy_edges got rise=%0d fall=%0d want 1/1", a_rise.size(), a_fall.size());
            end
        end
    endtask

    task automatic test_glitch();
        clear_logs();
        drive_bit(0, 1'b0, 4);
        drive_bit(0, 1'b1, 3 * CPB);
        checks += 4;
        if (a_dv.size() !== 0 || a_fe.size() !== 0) begin
            errors++; $display("FAIL glitch_strobes got dv=%0d fe=%0d want 0/0", a_dv.size(), a_fe.size());
        end
        if (a_set.size() !== 1 || a_done.size() !== 1) begin
            errors++; $display("FAIL glitch_samples got set=%0d done=%0d want 1/1", a_set.size(), a_done.size());
        end
        if (a_if.data_out !== 8'hA5) begin errors++; $display("FAIL glitch_data_out got %h want a5", a_if.data_out); end
        if (a_if.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", a_if.busy); end
        if (a_rise.size() == 1 && a_fall.size() == 1) begin
            checks++;
            if (a_fall[0] - a_rise[0] !== CPB / 2) begin
                errors++; $display("FAIL glitch_busy_len got %0d want %0d", a_fall[0] - a_rise[0], CPB / 2);
            end
        end
    endtask

    task automatic test_frame_break();
        clear_logs();
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        drive_bit(0, 1'b0, 40);
        checks += 3;
        if (a_fe.size() !== 1) begin errors++; $display("FAIL break_fe_count got %0d want 1", a_fe.size()); end
        if (a_dv.size() !== 0) begin errors++; $display("FAIL break_dv_count got %0d want 0", a_dv.size()); end
        if (a_if.data_out !== 8'hA5) begin errors++; $display("FAIL break_data_out got %h want a5", a_if.data_out); end
        drive_bit(0, 1'b1, 2 * CPB);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1, 2 * CPB);
        checks += 3;
        if (a_fe.size() !== 1) begin errors++; $display("FAIL break_fe_total got %0d want 1", a_fe.size()); end
        if (a_done.size() !== 20) begin errors++; $display("FAIL break_samples got %0d want 20", a_done.size()); end
        if (a_dv.size() !== 1) begin
            errors++; $display("FAIL break_next_dv got %0d want 1", a_dv.size());
        end else if (a_dat[0] !== 8'h5A) begin
            errors++; $display("FAIL break_next_data got %h want 5a", a_dat[0]);
        end
    endtask

    task automatic test_parity();
        clear_logs();
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        drive_bit(1, 1'b1, 2 * CPB);
        checks += 2;
        if (p_fe.size() !== 0) begin errors++; $display("FAIL parity_fe got %0d want 0", p_fe.size()); end
        if (p_dv.size() !== 2) begin
            errors++; $display("FAIL parity_dv_count got %0d want 2", p_dv.size());
        end else begin
            checks += 4;
            if (p_dat[0] !== 8'h07) begin errors++; $display("FAIL parity_data0 got %h want 07", p_dat[0]); end
            if (p_pe[0] !== 1'b0) begin errors++; $display("FAIL parity_err0 got %b want 0", p_pe[0]); end
            if (p_dat[1] !== 8'h07) begin errors++; $display("FAIL parity_data1 got %h want 07", p_dat[1]); end
            if (p_pe[1] !== 1'b1) begin errors++; $display("FAIL parity_err1 got %b want 1", p_pe[1]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1, 2 * CPB);
        checks++;
        if (a_dv.size() !== 2) begin
            errors++; $display("FAIL b2b_dv_count got %0d want 2", a_dv.size());
        end else begin
            checks += 3;
            if (a_dat[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0 got %h want 00", a_dat[0]); end
            if (a_dat[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1 got %h want ff", a_dat[1]); end
            if (a_dv[1] - a_dv[0] !== 10 * CPB) begin
                errors++; $display("FAIL b2b_gap got %0d want %0d", a_dv[1] - a_dv[0], 10 * CPB);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        drive_bit(0, 1'b0, CPB);
        drive_bit(0, 1'b1, CPB);
        drive_bit(0, 1'b0, CPB);
        drive_bit(0, 1'b0, CPB);
        drive_bit(0, 1'b0, CPB / 2);
        #2 rst = 1'b0;
        a_if.rx = 1'b1;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive_bit(0, 1'b1, 3 * CPB);
        checks++;
        if (a_dv.size() !== 0 || a_fe.size() !== 0) begin
            errors++; $display("FAIL midreset_strobes got dv=%0d fe=%0d want 0/0", a_dv.size(), a_fe.size());
        end
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1, 2 * CPB);
        checks++;
        if (a_dv.size() !== 1) begin
            errors++; $display("FAIL midreset_dv_count got %0d want 1", a_dv.size());
        end else if (a_dat[0] !== 8'h81) begin
            errors++; $display("FAIL midreset_data got %h want 81", a_dat[0]);
        end
    endtask

    initial begin
        a_if.rx = 1'b1;
        p_if.rx = 1'b1;
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_break();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
